// File: rtl/iterative_mul_div_if.sv
// Request/response bundle for the iterative multiply/divide unit.
//   master : issuing pipeline stage (drives request, consumes response)
//   slave  : iterative_mul_div
// Signals:
//   reqValid/reqReady   request handshake
//   command[2:0]        MulDivCommand (Mul=0 ... Remu=7)
//   wordOp              RV64 *W form (ignored when XLEN=32)
//   src1/src2           operands
//   respValid/respReady response handshake
//   result              operation result
interface iterative_mul_div_if #(parameter int XLEN = 32);
  logic            reqValid;
  logic            reqReady;
  logic [2:0]      command;
  logic            wordOp;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            respValid;
  logic            respReady;
  logic [XLEN-1:0] result;

  modport master (
    output reqValid, command, wordOp, src1, src2, respReady,
    input  reqReady, respValid, result
  );

  modport slave (
    input  reqValid, command, wordOp, src1, src2, respReady,
    output reqReady, respValid, result
  );
endinterface

// File: rtl/iterative_mul_div.sv
// Iterative multiply/divide execution unit, one result bit per cycle.
// Shift-add multiply on operand magnitudes, restoring divide on magnitudes,
// sign fix-up applied when the last step completes. Divide-by-zero and
// signed overflow finish without iterating.
// Ports:
//   clk    clock, rising edge
//   rstN   asynchronous active-low reset
//   flush  abandon in-flight/pending work, return to Idle
//   bus    request/response handshake bundle (slave side)
//
// state | meaning
// Idle  | ready for a request
// Busy  | iterating, cnt steps remaining
// Done  | result held, waiting for respReady
module iterative_mul_div #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rstN,
  input  logic flush,
  iterative_mul_div_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] CmdMul    = 3'd0;
  localparam logic [2:0] CmdMulh   = 3'd1;
  localparam logic [2:0] CmdMulhsu = 3'd2;
  localparam logic [2:0] CmdMulhu  = 3'd3;
  localparam logic [2:0] CmdDiv    = 3'd4;
  localparam logic [2:0] CmdRem    = 3'd6;

  typedef enum logic [1:0] {Idle, Busy, Done} stateE;

  stateE state, stateNext;

  logic [CW-1:0]     cnt;
  logic [2:0]        cmdR;
  logic              wordR;
  logic              negQ;
  logic              negR;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   resultReg;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction

  // Word results are always sign-extended from bit 31, even for Divu/Remu.
  function automatic logic [XLEN-1:0] fmtResult(input logic [XLEN-1:0] raw, input logic word);
    return word ? sext32(raw[31:0]) : raw;
  endfunction

  // ---------------- request-side operand preparation ----------------
  logic            effWord;
  logic            isDivIn;
  logic            sgn1In, sgn2In;
  logic [XLEN-1:0] op1, op2, mag1, mag2, mostNeg, specRaw;
  logic            neg1, neg2, divZero, divOvf, special, accept;

  always_comb begin
    effWord = (XLEN == 64) && bus.wordOp;
    isDivIn = bus.command[2];
    sgn1In  = (bus.command == CmdMulh) || (bus.command == CmdMulhsu) ||
              (bus.command == CmdDiv)  || (bus.command == CmdRem);
    sgn2In  = (bus.command == CmdMulh) || (bus.command == CmdDiv) ||
              (bus.command == CmdRem);

    op1 = bus.src1;
    op2 = bus.src2;
    if (effWord) begin
      op1 = sgn1In ? sext32(bus.src1[31:0]) : zext32(bus.src1[31:0]);
      op2 = sgn2In ? sext32(bus.src2[31:0]) : zext32(bus.src2[31:0]);
    end

    neg1 = sgn1In && op1[XLEN-1];
    neg2 = sgn2In && op2[XLEN-1];
    mag1 = neg1 ? -op1 : op1;
    mag2 = neg2 ? -op2 : op2;

    mostNeg = effWord ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    divZero = isDivIn && (op2 == '0);
    divOvf  = isDivIn && !bus.command[0] && (op1 == mostNeg) && (op2 == '1);
    special = divZero || divOvf;

    // command[1] separates Rem/Remu from Div/Divu.
    if (divZero) specRaw = bus.command[1] ? op1 : '1;
    else         specRaw = bus.command[1] ? '0  : op1;

    accept = bus.reqValid && (state == Idle) && !flush;
  end

  // ---------------- iteration step ----------------
  logic [2*XLEN-1:0] accNext, prodFull;
  logic [XLEN:0]     remShift, remDiff;
  logic              remGe;
  logic [XLEN-1:0]   remNext, quoNext, quoSigned, remSigned, rawResult;

  always_comb begin
    accNext  = mplier[0] ? acc + mcand : acc;
    remShift = {rem, quo[XLEN-1]};
    remDiff  = remShift - {1'b0, divisor};
    remGe    = !remDiff[XLEN];
    remNext  = remGe ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
    quoNext  = {quo[XLEN-2:0], remGe};

    prodFull  = negQ ? -accNext : accNext;
    quoSigned = negQ ? -quoNext : quoNext;
    remSigned = negR ? -remNext : remNext;

    case (cmdR)
      CmdMul:                      rawResult = prodFull[XLEN-1:0];
      CmdMulh, CmdMulhsu, CmdMulhu: rawResult = wordR ? prodFull[XLEN-1:0]
                                                      : prodFull[2*XLEN-1:XLEN];
      default:                     rawResult = cmdR[1] ? remSigned : quoSigned;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= Idle;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      Idle:    if (accept) stateNext = special ? Done : Busy;
      Busy:    if (cnt == CW'(1)) stateNext = Done;
      Done:    if (bus.respReady) stateNext = Idle;
      default: stateNext = Idle;
    endcase
    if (flush) stateNext = Idle;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt       <= '0;
      cmdR      <= '0;
      wordR     <= 1'b0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      divisor   <= '0;
      resultReg <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      if (special) begin
        resultReg <= fmtResult(specRaw, effWord);
      end else begin
        cnt     <= effWord ? CW'(32) : CW'(XLEN);
        cmdR    <= bus.command;
        wordR   <= effWord;
        negQ    <= neg1 ^ neg2;
        negR    <= neg1;
        mcand   <= {{XLEN{1'b0}}, mag1};
        acc     <= '0;
        mplier  <= mag2;
        // Left-align a 32-bit word dividend so the restoring loop sees its MSB first.
        quo     <= effWord ? (mag1 << (XLEN - 32)) : mag1;
        rem     <= '0;
        divisor <= mag2;
      end
    end else if (state == Busy) begin
      cnt    <= cnt - CW'(1);
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= remNext;
      quo    <= quoNext;
      if (cnt == CW'(1)) resultReg <= fmtResult(rawResult, wordR);
    end
  end

  assign bus.reqReady  = (state == Idle);
  assign bus.respValid = (state == Done);
  assign bus.result    = resultReg;

endmodule

// File: tb/tb_iterative_mul_div.sv
module tb_iterative_mul_div;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterative_mul_div_if #(.XLEN(32)) b32 ();
  iterative_mul_div_if #(.XLEN(64)) b64 ();

  iterative_mul_div #(.XLEN(32)) dut32 (.clk(clk), .rstN(rstN), .flush(flush), .bus(b32));
  iterative_mul_div #(.XLEN(64)) dut64 (.clk(clk), .rstN(rstN), .flush(flush), .bus(b64));

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } expT;
  expT expQ[$];

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rdy(input bit sel);
    return sel ? 64'(b64.reqReady) : 64'(b32.reqReady);
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? b64.respValid : b32.respValid;
  endfunction

  function automatic logic [63:0] res(input bit sel);
    return sel ? b64.result : {32'b0, b32.result};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [2:0] cmd, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    if (sel) begin
      b64.reqValid = v; b64.command = cmd; b64.wordOp = w; b64.src1 = a; b64.src2 = b;
    end else begin
      b32.reqValid = v; b32.command = cmd; b32.wordOp = w; b32.src1 = a[31:0]; b32.src2 = b[31:0];
    end
  endtask

  task automatic setReady(input bit sel, input logic r);
    if (sel) b64.respReady = r;
    else     b32.respReady = r;
  endtask

  // Issue one request, wait for its response, check latency/result, hand it off.
  task automatic op(input bit sel, input logic [2:0] cmd, input logic w, input logic [63:0] a,
                    input logic [63:0] b, input logic [63:0] expRes, input int expCyc,
                    input int stall, input string tag);
    expT e;
    int k;
    @(negedge clk);
    chk({tag, "_reqReady"}, rdy(sel), 64'd1);
    drive(sel, 1'b1, cmd, w, a, b);
    expQ.push_back('{res: expRes, cyc: expCyc});
    @(posedge clk);
    #1 drive(sel, 1'b0, cmd, w, a, b);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!vld(sel) && k < 200);
    e = expQ.pop_front();
    chk({tag, "_cycle"}, 64'(k), 64'(e.cyc));
    chk({tag, "_result"}, res(sel), e.res);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stallResult"}, res(sel), e.res);
      chk({tag, "_stallReqReady"}, rdy(sel), 64'd0);
      chk({tag, "_stallValid"}, 64'(vld(sel)), 64'd1);
    end
    setReady(sel, 1'b1);
    @(posedge clk);
    #1 setReady(sel, 1'b0);
    chk({tag, "_readyAfter"}, rdy(sel), 64'd1);
  endtask

  initial begin
    bit sawValid;
    drive(0, 1'b0, MUL, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, MUL, 1'b0, 64'd0, 64'd0);
    setReady(0, 1'b0);
    setReady(1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_reqReady32", rdy(0), 64'd1);
    chk("rst_respValid32", 64'(vld(0)), 64'd0);
    chk("rst_result32", res(0), 64'd0);
    chk("rst_reqReady64", rdy(1), 64'd1);
    chk("rst_result64", res(1), 64'd0);
    rstN = 1'b1;

    // XLEN = 32
    op(0, MUL,    0, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB, 33, 0, "mul32");
    op(0, MULHU,  0, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, 0, "mulhu32");
    op(0, MULH,   0, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'h0,         33, 0, "mulh32");
    op(0, MULHSU, 0, 64'hFFFF_FFFF,  64'd2,         64'hFFFF_FFFF, 33, 0, "mulhsu32");
    op(0, DIV,    0, 64'h8000_0000,  64'hFFFF_FFFF, 64'h8000_0000, 1,  0, "divOvf32");
    op(0, REM,    0, 64'h8000_0000,  64'hFFFF_FFFF, 64'h0,         1,  0, "remOvf32");
    op(0, DIVU,   0, 64'h1234,       64'd0,         64'hFFFF_FFFF, 1,  0, "divuZero32");
    op(0, REMU,   0, 64'h1234,       64'd0,         64'h1234,      1,  0, "remuZero32");
    op(0, REM,    0, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFF, 33, 0, "remNeg32");
    op(0, DIV,    0, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFD, 33, 0, "divNeg32");
    op(0, DIVU,   0, 64'd100,        64'd7,         64'd14,        33, 0, "divu32");
    op(0, REMU,   0, 64'd100,        64'd7,         64'd2,         33, 5, "remuStall32");
    op(0, DIV,    0, 64'd8,          64'd0,         64'hFFFF_FFFF, 1,  0, "divZeroBackToBack32");

    // Flush of a busy multiply
    @(negedge clk);
    drive(0, 1'b1, MUL, 1'b0, 64'd5, 64'd6);
    @(posedge clk);
    #1 drive(0, 1'b0, MUL, 1'b0, 64'd5, 64'd6);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_reqReady", rdy(0), 64'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vld(0)) sawValid = 1'b1;
    end
    chk("flush_noResp", 64'(sawValid), 64'd0);

    // A request presented together with flush is dropped
    @(negedge clk);
    drive(0, 1'b1, DIVU, 1'b0, 64'd9, 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; drive(0, 1'b0, DIVU, 1'b0, 64'd9, 64'd0); end
    @(negedge clk);
    chk("flushReq_notAccepted", rdy(0), 64'd1);
    chk("flushReq_noResp", 64'(vld(0)), 64'd0);
    op(0, DIVU,   0, 64'd9,          64'd3,         64'd3,         33, 0, "divuAfterFlush32");

    // XLEN = 64
    op(1, DIV,  1, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 33, 0, "divW64");
    op(1, DIV,  0, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'h0000_0000_7FFF_FFFC, 65, 0, "div64");
    op(1, DIVU, 1, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'h0000_0000_7FFF_FFFC, 33, 0, "divuW64");
    op(1, MUL,  1, 64'h1234_5678_0000_8000, 64'h0000_0001_0001_0000,
       64'hFFFF_FFFF_8000_0000, 33, 0, "mulW64");
    op(1, MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
       64'hFFFF_FFFF_FFFF_FFFE, 65, 0, "mulhu64");
    op(1, MULH,  0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 65, 0, "mulh64");
    op(1, DIV,  1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
       64'hFFFF_FFFF_8000_0000, 1, 0, "divOvfW64");
    op(1, REMU, 1, 64'h0000_0000_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1, 0, "remuZeroW64");

    // Asynchronous reset mid-operation
    @(negedge clk);
    drive(1, 1'b1, MUL, 1'b0, 64'd3, 64'd4);
    @(posedge clk);
    #1 drive(1, 1'b0, MUL, 1'b0, 64'd3, 64'd4);
    repeat (5) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("asyncRst_reqReady", rdy(1), 64'd1);
    chk("asyncRst_result", res(1), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (vld(1)) sawValid = 1'b1;
    end
    chk("asyncRst_noResp", 64'(sawValid), 64'd0);
    op(1, REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, "remAfterRst64");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_mul_div.md
# iterative_mul_div

Parametrised iterative multiply/divide execution unit for the `ExUnitType_MulDiv` slot of the integer pipeline. It executes all eight `MulDivCommand` operations at a configurable XLEN. When XLEN is 64 it also executes the RV64 word (`*W`) forms. A one-bit-per-cycle datapath (shift-add multiply, restoring divide) keeps area small. Valid/ready handshakes sit on both the request and response sides, and a flush input abandons in-flight work.

## Interface
- `XLEN`, default 32: operand/result width; legal values 32 and 64.
- `clk` input 1: sole clock, rising edge.
- `rstN` input 1: asynchronous, active-low reset.
- `flush` input 1: abandon any in-flight or pending operation.
- `reqValid` input 1: request present.
- `reqReady` output 1: unit can accept a request.
- `command` input 3: `MulDivCommand` encoding (Mul=0 … Remu=7).
- `wordOp` input 1: RV64 `*W` form; ignored when XLEN=32.
- `src1` input XLEN: rs1 / dividend / multiplicand.
- `src2` input XLEN: rs2 / divisor / multiplier.
- `respValid` output 1: result available.
- `respReady` input 1: consumer accepts result.
- `result` output XLEN: operation result.

## Operation
- States: Idle, Busy, Done.
- Idle → Busy on `reqValid && reqReady && !flush`. The unit latches command, wordOp and the prepared operands, and loads the iteration counter with N.
  - N = 32 if (wordOp && XLEN=64), else XLEN.
- Idle → Done directly for divide special cases, with no iterations:
  - Divisor zero: Div/Divu give all-ones. Rem/Remu give the dividend.
  - Signed overflow, Div/Rem only: dividend = most-negative and divisor = -1. Div gives the dividend; Rem gives 0.
- Busy:
  - Counter decrements each cycle.
  - Multiply: one shift-add step per cycle into a 2N-bit product.
  - Divide: one restoring subtract step per cycle on the magnitudes.
  - Busy → Done when the counter reaches 0.
- Done: `respValid`=1. Done → Idle on `respReady`.
- Signedness:
  - Mulh uses signed×signed. Mulhsu uses signed×unsigned. Mulhu and Mul use unsigned×unsigned; Mul takes the low N bits, which are sign-agnostic.
  - Div and Rem operate on magnitudes. Quotient sign = sign1 XOR sign2; remainder sign = sign of the dividend.
- Word mode:
  - Operands are the low 32 bits, sign-extended for signed ops and zero-extended otherwise.
  - `result` = low 32 bits of the 32-bit result, sign-extended to 64 bits. Divu/Remu word results are also sign-extended from bit 31.
  - Mulh/Mulhsu/Mulhu with wordOp behave as Mul-word; the decoder never issues them.
- Result select:
  - Mul: low N bits of the product.
  - Mulh*: high N bits of the product.
  - Div/Divu: quotient.
  - Rem/Remu: remainder.
- `flush`: from any state, next state is Idle and `respValid` deasserts the following cycle. A request presented in the same cycle as flush is not accepted.

## Timing
- Reset values: state Idle, `reqReady`=1, `respValid`=0, `result`=0, counter 0.
- `reqReady` = (state == Idle), registered-state derived, with no combinational path from `reqValid`.
- Accept in cycle 0 → Busy in cycles 1..N → `respValid` first high in cycle N+1.
- Special-case divides: `respValid` high in cycle 1.
- `result` is stable while `respValid`=1 and not yet accepted.
- Back-to-back issue: after the response handshake in cycle k, `reqReady` is 1 in cycle k+1. Minimum initiation interval is N+2 cycles, or 2 for special cases.
- `rstN` assertion mid-operation forces Idle immediately (asynchronously). The result is discarded.
- `respReady` held low: the unit stalls in Done indefinitely with no loss of the result.

## Test plan
- XLEN=32, Mul, src1=7, src2=0xFFFFFFFD → `respValid` at cycle 33, `result`=0xFFFFFFEB; Mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; Mulh same operands → 0x00000000.
- XLEN=32, Div 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1; Rem same operands → 0; Divu 0x1234/0 → 0xFFFFFFFF at cycle 1; Remu 0x1234/0 → 0x1234.
- XLEN=32, Rem 0xFFFFFFF9 (-7) by 2 → 0xFFFFFFFF; Div same operands → 0xFFFFFFFD; Divu 100/7 → 14, Remu 100/7 → 2.
- XLEN=64, wordOp Div, src1=0x00000000_FFFFFFF8, src2=2 → `respValid` at cycle 33, `result`=0xFFFFFFFF_FFFFFFFC; non-word Div of the same operands → 0x00000000_7FFFFFFC at cycle 65.
- Flush at cycle 10 of a Busy Mul → `respValid` never asserts; `reqReady`=1 at cycle 11; a new Divu 9/3 then returns 3.
- `respReady` held low 5 cycles after `respValid` → `result` constant and `reqReady`=0 throughout; a new request in the cycle after the handshake is accepted.
